// File: rtl/snoop_bus_arbiter.sv
// rtl/snoop_bus_arbiter.sv - round-robin MSI snooping-bus arbiter with write-back sequencing.
// Optional write-back watchdog enabled by defining SNOOP_WB_TIMEOUT_EN.
module snoop_bus_arbiter #(
  parameter int N          = 4,
  parameter int AW         = 8,
  parameter int WB_TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [2*N-1:0]  op_in,
  input  logic [AW*N-1:0] addr_in,
  input  logic [N-1:0]    snoop_wb,
  input  logic            wb_done,
  output logic [N-1:0]    grant,
  output logic            bus_valid,
  output logic [1:0]      bus_op,
  output logic [AW-1:0]   bus_addr,
  output logic [2:0]      bus_src,
  output logic            wb_req,
  output logic [N-1:0]    done,
  output logic            err
);

  localparam int IW = (N > 2) ? $clog2(N) : 1;
  localparam logic [1:0] OP_INV = 2'b01;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [2:0] {IDLE, BROADCAST, SNOOP, WRITEBACK, DONE} state_t;

  state_t      state;
  logic [2:0]  rr_ptr;
  logic [2:0]  owner;
  logic [1:0]  own_op;
  logic        abort_pend;

`ifdef SNOOP_WB_TIMEOUT_EN
  logic [3:0]  wd_cnt;
`endif

  logic          sel_found;
  logic [2:0]    sel_idx;
  logic [1:0]    sel_op;
  logic [AW-1:0] sel_addr;
  int            cand;

  // First requester after the last owner, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(rr_ptr) + k) % N;
      if (!sel_found && req[cand[IW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(cand);
      end
    end
    sel_op   = op_in[2*sel_idx +: 2];
    sel_addr = addr_in[AW*sel_idx +: AW];
  end

  logic hit;
  assign hit = |(snoop_wb & ~grant);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      bus_valid  <= 1'b0;
      bus_op     <= '0;
      bus_addr   <= '0;
      bus_src    <= '0;
      wb_req     <= 1'b0;
      done       <= '0;
      err        <= 1'b0;
      rr_ptr     <= 3'(N-1);
      owner      <= '0;
      own_op     <= '0;
      abort_pend <= 1'b0;
`ifdef SNOOP_WB_TIMEOUT_EN
      wd_cnt     <= '0;
`endif
    end else begin
      bus_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            owner  <= sel_idx;
            own_op <= sel_op;
            grant  <= N'(1) << sel_idx;
            if (sel_op == OP_ILL) begin
              abort_pend <= 1'b1;
              state      <= DONE;
            end else begin
              abort_pend <= 1'b0;
              bus_valid  <= 1'b1;
              bus_op     <= sel_op;
              bus_addr   <= sel_addr;
              bus_src    <= sel_idx;
              state      <= BROADCAST;
            end
          end
        end
        BROADCAST: state <= SNOOP;
        SNOOP: begin
          // An invalidate never needs the dirty line written back.
          if (hit && own_op != OP_INV) begin
            wb_req <= 1'b1;
`ifdef SNOOP_WB_TIMEOUT_EN
            wd_cnt <= '0;
`endif
            state  <= WRITEBACK;
          end else begin
            done  <= grant;
            state <= DONE;
          end
        end
        WRITEBACK: begin
          if (wb_done) begin
            wb_req <= 1'b0;
            done   <= grant;
            state  <= DONE;
          end
`ifdef SNOOP_WB_TIMEOUT_EN
          else if (wd_cnt == 4'(WB_TIMEOUT-1)) begin
            wb_req <= 1'b0;
            done   <= grant;
            err    <= 1'b1;
            state  <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 4'd1;
          end
`endif
        end
        DONE: begin
          // Aborted ops enter with no pulse yet; they spend one cycle issuing it.
          if (done == '0) begin
            done <= grant;
            err  <= abort_pend;
          end else begin
            done       <= '0;
            err        <= 1'b0;
            grant      <= '0;
            abort_pend <= 1'b0;
            rr_ptr     <= owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb/tb_snoop_bus_arbiter.sv - scoreboard bench for snoop_bus_arbiter.
module tb_snoop_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [2*N-1:0]  op_in;
  logic [AW*N-1:0] addr_in;
  logic [N-1:0]    snoop_wb;
  logic            wb_done;
  logic [N-1:0]    grant;
  logic            bus_valid;
  logic [1:0]      bus_op;
  logic [AW-1:0]   bus_addr;
  logic [2:0]      bus_src;
  logic            wb_req;
  logic [N-1:0]    done;
  logic            err;

  snoop_bus_arbiter #(.N(N), .AW(AW), .WB_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .req(req), .op_in(op_in), .addr_in(addr_in),
    .snoop_wb(snoop_wb), .wb_done(wb_done), .grant(grant), .bus_valid(bus_valid),
    .bus_op(bus_op), .bus_addr(bus_addr), .bus_src(bus_src), .wb_req(wb_req),
    .done(done), .err(err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {int c; logic [1:0] op; logic [7:0] addr; logic [2:0] src; logic [3:0] g;} bus_e;
  typedef struct {int c; logic [3:0] d; logic e;} done_e;
  typedef struct {int c; int len;} wb_e;

  bus_e  bus_q[$];
  done_e done_q[$];
  wb_e   wb_q[$];

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void exp_bus(int c, logic [1:0] op, logic [7:0] a, logic [2:0] s);
    bus_e e;
    e.c = c; e.op = op; e.addr = a; e.src = s; e.g = 4'(1) << s;
    bus_q.push_back(e);
  endfunction

  function automatic void exp_done(int c, logic [3:0] d, logic e);
    done_e x;
    x.c = c; x.d = d; x.e = e;
    done_q.push_back(x);
  endfunction

  function automatic void exp_wb(int c, int len);
    wb_e x;
    x.c = c; x.len = len;
    wb_q.push_back(x);
  endfunction

  // Monitor: compares every DUT-presented event against the queued expectation.
  logic prev_wb = 1'b0;
  int   wb_start = 0;
  always @(negedge clock) begin
    bus_e  be;
    done_e de;
    wb_e   we;
    if (grant != '0) chk("grant_onehot", $countones(grant), 1);
    if (bus_valid) begin
      if (bus_q.size() == 0) chk("unexpected_bus_valid", 1, 0);
      else begin
        be = bus_q.pop_front();
        chk("bus_cycle", cyc, be.c);
        chk("bus_op", int'(bus_op), int'(be.op));
        chk("bus_addr", int'(bus_addr), int'(be.addr));
        chk("bus_src", int'(bus_src), int'(be.src));
        chk("bus_grant", int'(grant), int'(be.g));
      end
    end
    if (done != '0 || err) begin
      if (done_q.size() == 0) chk("unexpected_done", int'(done), 0);
      else begin
        de = done_q.pop_front();
        chk("done_cycle", cyc, de.c);
        chk("done_vec", int'(done), int'(de.d));
        chk("done_err", int'(err), int'(de.e));
        chk("done_grant", int'(grant), int'(de.d));
      end
    end
    if (wb_req && !prev_wb) wb_start = cyc;
    if (!wb_req && prev_wb) begin
      if (wb_q.size() == 0) chk("unexpected_wb_req", 1, 0);
      else begin
        we = wb_q.pop_front();
        chk("wb_start", wb_start, we.c);
        chk("wb_len", cyc - wb_start, we.len);
      end
    end
    prev_wb = wb_req;
  end

  // Requesters drop req on their done pulse.
  always @(negedge clock) if (done != '0) req = req & ~done;

  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; snoop_wb = '0; wb_done = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_grant"}, int'(grant), 0);
    chk({tag, "_bus_valid"}, int'(bus_valid), 0);
    chk({tag, "_bus_op"}, int'(bus_op), 0);
    chk({tag, "_bus_addr"}, int'(bus_addr), 0);
    chk({tag, "_bus_src"}, int'(bus_src), 0);
    chk({tag, "_wb_req"}, int'(wb_req), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    reset = 1'b1; req = '0; op_in = '0; addr_in = '0; snoop_wb = '0; wb_done = 1'b0;
    tick(2);
    chk_zero("reset");
    reset = 1'b0;
    tick(1);

    // Single readMiss, no write-back
    op_in[1:0] = 2'b00; addr_in[7:0] = 8'h3A;
    base = cyc;
    exp_bus(base + 1, 2'b00, 8'h3A, 3'd0);
    exp_done(base + 3, 4'b0001, 1'b0);
    req = 4'b0001;
    tick(6);

    // Round-robin with all four requesting; requester 0 re-requests later
    do_reset();
    tick(1);
    op_in = '0;
    addr_in = {8'h13, 8'h12, 8'h11, 8'h10};
    base = cyc;
    for (int k = 0; k < 5; k++) begin
      exp_bus(base + 1 + 4*k, 2'b00, 8'h10 + 8'(k % 4), 3'(k % 4));
      exp_done(base + 3 + 4*k, 4'(1) << (k % 4), 1'b0);
    end
    req = 4'b1111;
    tick(4);
    req = req | 4'b0001;
    tick(17);

    // writeMiss with another cache holding the line dirty
    op_in[3:2] = 2'b10; addr_in[15:8] = 8'h55; snoop_wb = 4'b0100;
    base = cyc;
    exp_bus(base + 1, 2'b10, 8'h55, 3'd1);
    exp_wb(base + 3, 3);
    exp_done(base + 6, 4'b0010, 1'b0);
    req = 4'b0010;
    tick(5);
    wb_done = 1'b1;
    tick(1);
    wb_done = 1'b0; snoop_wb = '0;
    tick(2);

    // Invalidate ignores snoop hits
    op_in[1:0] = 2'b01; addr_in[7:0] = 8'h77; snoop_wb = 4'b1110;
    base = cyc;
    exp_bus(base + 1, 2'b01, 8'h77, 3'd0);
    exp_done(base + 3, 4'b0001, 1'b0);
    req = 4'b0001;
    tick(5);

    // Owner's own snoop_wb bit is ignored
    op_in[1:0] = 2'b00; addr_in[7:0] = 8'h21; snoop_wb = 4'b0001;
    base = cyc;
    exp_bus(base + 1, 2'b00, 8'h21, 3'd0);
    exp_done(base + 3, 4'b0001, 1'b0);
    req = 4'b0001;
    tick(5);
    snoop_wb = '0;

    // Illegal op: no broadcast, done with err in cycle 2
    op_in[5:4] = 2'b11; addr_in[23:16] = 8'h99;
    base = cyc;
    exp_done(base + 2, 4'b0100, 1'b1);
    req = 4'b0100;
    tick(4);
    chk("bus_addr_hold", int'(bus_addr), 8'h21);
    chk("bus_src_hold", int'(bus_src), 0);

`ifdef SNOOP_WB_TIMEOUT_EN
    // Write-back never acknowledged: watchdog aborts
    op_in[1:0] = 2'b10; addr_in[7:0] = 8'h44; snoop_wb = 4'b0010;
    base = cyc;
    exp_bus(base + 1, 2'b10, 8'h44, 3'd0);
    exp_wb(base + 3, 15);
    exp_done(base + 18, 4'b0001, 1'b1);
    req = 4'b0001;
    tick(20);
    snoop_wb = '0;
`endif

    // Reset during WRITEBACK: outputs cleared, no done
    op_in[1:0] = 2'b10; addr_in[7:0] = 8'h66; snoop_wb = 4'b0100;
    base = cyc;
    exp_bus(base + 1, 2'b10, 8'h66, 3'd0);
    exp_wb(base + 3, 2);
    req = 4'b0001;
    tick(4);
    reset = 1'b1;
    tick(1);
    chk_zero("midreset");
    reset = 1'b0; req = '0; snoop_wb = '0;
    tick(6);

    chk("bus_q_empty", bus_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    chk("wb_q_empty", wb_q.size(), 0);
    chk("wb_req_idle", int'(wb_req), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
